// File: rtl/st_port_arbiter_pkg.sv
// st_port_arbiter_pkg: shared store-port types and constants (optional feature macro: ST_PORT_ARB_LOCK_EN).
// Rev 1.0
`default_nettype none
package st_port_arbiter_pkg;

  localparam int ST_ARB_MAX_PORTS = 8;
  localparam int ST_IDX_W         = 12;
  localparam int ST_TAG_W         = 44;
  localparam int ST_DATA_W        = 64;
  localparam int ST_BE_W          = ST_DATA_W / 8;

  typedef struct packed {
    logic [ST_IDX_W-1:0]  idx;
    logic [ST_TAG_W-1:0]  tag;
    logic [ST_DATA_W-1:0] data;
    logic [ST_BE_W-1:0]   be;
    logic [1:0]           size;
  } st_port_req_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } st_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/st_port_arbiter_if.sv
// st_port_arbiter_if: requester and dcache-side signals of the store-port arbiter.
// Rev 1.0 -- lock_i exists only when ST_PORT_ARB_LOCK_EN is defined.
`default_nettype none
interface st_port_arbiter_if
  import st_port_arbiter_pkg::*;
#(
  parameter int NR_PORTS = 3,
  parameter int IDX_W    = ST_IDX_W,
  parameter int TAG_W    = ST_TAG_W,
  parameter int DATA_W   = ST_DATA_W,
  parameter int BE_W     = DATA_W / 8
);
  localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  logic [NR_PORTS-1:0]        req_i;
  logic [NR_PORTS-1:0]        gnt_o;
  logic [NR_PORTS*IDX_W-1:0]  idx_i;
  logic [NR_PORTS*TAG_W-1:0]  tag_i;
  logic [NR_PORTS*DATA_W-1:0] data_i;
  logic [NR_PORTS*BE_W-1:0]   be_i;
  logic [NR_PORTS*2-1:0]      size_i;
`ifdef ST_PORT_ARB_LOCK_EN
  logic [NR_PORTS-1:0]        lock_i;
`endif
  logic                       dc_req_o;
  logic                       dc_gnt_i;
  logic [IDX_W-1:0]           dc_idx_o;
  logic [TAG_W-1:0]           dc_tag_o;
  logic [DATA_W-1:0]          dc_data_o;
  logic [BE_W-1:0]            dc_be_o;
  logic [1:0]                 dc_size_o;
  logic [PTR_W-1:0]           dc_owner_o;
  logic                       busy_o;

  modport slave (
`ifdef ST_PORT_ARB_LOCK_EN
    input  lock_i,
`endif
    input  req_i, idx_i, tag_i, data_i, be_i, size_i, dc_gnt_i,
    output gnt_o, dc_req_o, dc_idx_o, dc_tag_o, dc_data_o, dc_be_o,
    output dc_size_o, dc_owner_o, busy_o
  );

  modport master (
`ifdef ST_PORT_ARB_LOCK_EN
    output lock_i,
`endif
    output req_i, idx_i, tag_i, data_i, be_i, size_i, dc_gnt_i,
    input  gnt_o, dc_req_o, dc_idx_o, dc_tag_o, dc_data_o, dc_be_o,
    input  dc_size_o, dc_owner_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/st_port_arbiter_rr_pick.sv
// st_port_arbiter_rr_pick: combinational round-robin picker, first set request at or after the pointer.
// Rev 1.0
`default_nettype none
module st_port_arbiter_rr_pick
  import st_port_arbiter_pkg::*;
#(
  parameter int NR_PORTS = 3,
  parameter int PTR_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic [NR_PORTS-1:0] i_req,
  input  logic [PTR_W-1:0]    i_ptr,
  output logic [NR_PORTS-1:0] o_gnt,
  output logic [PTR_W-1:0]    o_idx,
  output logic                o_any
);

  int w_j;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int i = NR_PORTS - 1; i >= 0; i--) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= NR_PORTS) w_j = w_j - NR_PORTS;
      if (i_req[w_j]) begin
        o_idx = PTR_W'(w_j);
        o_any = 1'b1;
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/st_port_arbiter.sv
// st_port_arbiter: round-robin share of the dcache store port with a one-entry registered output stage.
// Rev 1.0 -- optional locked multi-beat ownership under ST_PORT_ARB_LOCK_EN.
`default_nettype none
module st_port_arbiter
  import st_port_arbiter_pkg::*;
#(
  parameter int NR_PORTS = 3,
  parameter int IDX_W    = 12,
  parameter int TAG_W    = 44,
  parameter int DATA_W   = 64,
  parameter int BE_W     = DATA_W / 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  st_port_arbiter_if.slave   bus
);

  localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  st_arb_state_e       r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_rr, w_rr_nxt;
  logic [PTR_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_idx;
  logic [TAG_W-1:0]    r_tag;
  logic [DATA_W-1:0]   r_data;
  logic [BE_W-1:0]     r_be;
  logic [1:0]          r_size;

  logic [NR_PORTS-1:0] w_req_eff;
  logic [NR_PORTS-1:0] w_pick_gnt;
  logic [PTR_W-1:0]    w_win;
  logic                w_any;
  logic                w_accept;
  logic [PTR_W-1:0]    w_win_next;

`ifdef ST_PORT_ARB_LOCK_EN
  logic                r_locked, w_locked_nxt;

  // A locked owner is the only requester visible to the picker.
  always_comb begin
    w_req_eff = bus.req_i;
    if (r_locked) w_req_eff = bus.req_i & (NR_PORTS'(1) << r_owner);
  end
`else
  always_comb begin
    w_req_eff = bus.req_i;
  end
`endif

  st_port_arbiter_rr_pick #(
    .NR_PORTS (NR_PORTS),
    .PTR_W    (PTR_W)
  ) u_rr_pick (
    .i_req (w_req_eff),
    .i_ptr (r_rr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_win),
    .o_any (w_any)
  );

  assign w_win_next = (w_win == PTR_W'(NR_PORTS - 1)) ? '0 : w_win + PTR_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    bus.gnt_o   = '0;
`ifdef ST_PORT_ARB_LOCK_EN
    w_locked_nxt = r_locked;
`endif
    w_accept = ((r_state == ST_EMPTY) || bus.dc_gnt_i) && w_any;

    unique case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (bus.dc_gnt_i && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase

    if (w_accept) begin
      bus.gnt_o = w_pick_gnt;
`ifdef ST_PORT_ARB_LOCK_EN
      w_locked_nxt = bus.lock_i[w_win];
      if (!bus.lock_i[w_win]) w_rr_nxt = w_win_next;
`else
      w_rr_nxt = w_win_next;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

`ifdef ST_PORT_ARB_LOCK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_locked <= 1'b0;
    else       r_locked <= w_locked_nxt;
  end
`endif

  // Payload only moves on accept, so it stays bit-stable while the cache stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner <= '0;
      r_idx   <= '0;
      r_tag   <= '0;
      r_data  <= '0;
      r_be    <= '0;
      r_size  <= '0;
    end else if (w_accept) begin
      r_owner <= w_win;
      r_idx   <= bus.idx_i[int'(w_win)*IDX_W +: IDX_W];
      r_tag   <= bus.tag_i[int'(w_win)*TAG_W +: TAG_W];
      r_data  <= bus.data_i[int'(w_win)*DATA_W +: DATA_W];
      r_be    <= bus.be_i[int'(w_win)*BE_W +: BE_W];
      r_size  <= bus.size_i[int'(w_win)*2 +: 2];
    end
  end

  assign bus.dc_req_o   = (r_state == ST_FULL);
  assign bus.busy_o     = (r_state == ST_FULL);
  assign bus.dc_owner_o = r_owner;
  assign bus.dc_idx_o   = r_idx;
  assign bus.dc_tag_o   = r_tag;
  assign bus.dc_data_o  = r_data;
  assign bus.dc_be_o    = r_be;
  assign bus.dc_size_o  = r_size;

endmodule
`default_nettype wire
